// File: rtl/uart_instr_loader.sv
// UART (8N1, LSB first) instruction downloader: pairs received bytes into
// big-endian 16-bit words and writes them to consecutive ROM addresses.
module uart_instr_loader #(
  parameter int CLKS_PER_BIT      = 868,
  parameter int ADDR_WIDTH        = 8,
  parameter int IDLE_TIMEOUT_BITS = 20
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_rx,
  output logic                  o_wr_en,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic [15:0]           o_wr_data,
  output logic [ADDR_WIDTH-1:0] o_max_addr,
  output logic                  o_load_done,
  output logic                  o_frame_err
);

  localparam int CNT_W   = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int TMO_CYC = IDLE_TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TMO_W   = $clog2(TMO_CYC + 1);

  localparam logic [CNT_W-1:0]      BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]      HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TMO_W-1:0]      TMO_LAST  = TMO_W'(TMO_CYC - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } rx_state_e;

  // Serial input and synchroniser
  logic rx_meta_q, rx_sync_q;

  // RX FSM
  rx_state_e  state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic             frame_err_q;

  // Word assembly and write port
  logic                  phase_q;
  logic [7:0]            hi_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  wr_en_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [15:0]           wr_data_q;
  logic [ADDR_WIDTH-1:0] max_addr_q;
  logic                  written_q;
  logic                  load_done_q;

  // Idle timeout
  logic [TMO_W-1:0] idle_cnt_q, idle_cnt_d;

  logic stop_sample;
  logic byte_ok;
  logic start_seen;
  logic idle_counting;
  logic timeout;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= i_rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // Stop-bit sample point; a high stop bit delivers the byte in shift_q.
  assign stop_sample = (state_q == S_STOP) && (cnt_q == BIT_LAST);
  assign byte_ok     = stop_sample && rx_sync_q && !load_done_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          cnt_q     <= '0;
          bit_idx_q <= '0;
          if (!rx_sync_q) state_q <= S_START;
        end
        S_START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q   <= '0;
            state_q <= rx_sync_q ? S_IDLE : S_DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DATA: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q     <= '0;
            shift_q   <= {rx_sync_q, shift_q[7:1]};
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) state_q <= S_STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_STOP: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q       <= '0;
            frame_err_q <= !rx_sync_q;
            state_q     <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // The timeout only runs once something has been written, so a line that
  // stays idle from power-up never declares an empty load complete.
  assign start_seen    = (state_q == S_IDLE) && !rx_sync_q;
  assign idle_counting = (state_q == S_IDLE) && rx_sync_q && written_q && !load_done_q;
  assign timeout       = idle_counting && (idle_cnt_q == TMO_LAST);

  always_comb begin
    idle_cnt_d = idle_cnt_q;
    if (start_seen) begin
      idle_cnt_d = '0;
    end else if (idle_counting) begin
      idle_cnt_d = idle_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      idle_cnt_q <= '0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      phase_q     <= 1'b0;
      hi_q        <= '0;
      addr_q      <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      max_addr_q  <= '0;
      written_q   <= 1'b0;
      load_done_q <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      if (byte_ok) begin
        if (!phase_q) begin
          hi_q    <= shift_q;
          phase_q <= 1'b1;
        end else begin
          wr_en_q    <= 1'b1;
          wr_addr_q  <= addr_q;
          wr_data_q  <= {hi_q, shift_q};
          max_addr_q <= addr_q;
          phase_q    <= 1'b0;
          written_q  <= 1'b1;
          // Address saturates at the top; the load ends there instead of wrapping.
          if (addr_q != ADDR_LAST) addr_q <= addr_q + 1'b1;
        end
      end
      if (wr_en_q && (wr_addr_q == ADDR_LAST)) load_done_q <= 1'b1;
      if (timeout) begin
        load_done_q <= 1'b1;
        phase_q     <= 1'b0;
      end
    end
  end

  assign o_wr_en     = wr_en_q;
  assign o_wr_addr   = wr_addr_q;
  assign o_wr_data   = wr_data_q;
  assign o_max_addr  = max_addr_q;
  assign o_load_done = load_done_q;
  assign o_frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_instr_loader.sv
// Randomised scoreboard bench for uart_instr_loader: a byte-level model
// predicts writes, frame errors and load completion.
module tb_uart_instr_loader;

  localparam int CPB    = 16;
  localparam int AW     = 3;
  localparam int ITB    = 20;
  localparam int N_WORD = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx = 1'b1;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;
  logic [AW-1:0] max_addr;
  logic          load_done;
  logic          frame_err;

  always #5 clk = ~clk;

  uart_instr_loader #(
    .CLKS_PER_BIT     (CPB),
    .ADDR_WIDTH       (AW),
    .IDLE_TIMEOUT_BITS(ITB)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_rx       (rx),
    .o_wr_en    (wr_en),
    .o_wr_addr  (wr_addr),
    .o_wr_data  (wr_data),
    .o_max_addr (max_addr),
    .o_load_done(load_done),
    .o_frame_err(frame_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [AW+15:0] exp_q[$];

  // Model state
  int         m_addr = 0;
  logic [7:0] m_hi = 8'h00;
  bit         m_pending = 1'b0;
  bit         m_done = 1'b0;
  int         m_frame_exp = 0;
  int         m_max_addr = 0;

  // Monitor state
  int  frame_seen = 0;
  bit  full_chk = 1'b0;
  bit  done_prev = 1'b0;
  time t_last_stop = 0;
  time t_done_rise = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_addr     = 0;
    m_hi       = 8'h00;
    m_pending  = 1'b0;
    m_done     = 1'b0;
    m_max_addr = 0;
  endtask

  task automatic model_byte(input logic [7:0] b, input bit stop_ok);
    logic [AW-1:0] a;
    if (!stop_ok) begin
      m_frame_exp++;
    end else if (!m_done) begin
      if (!m_pending) begin
        m_hi      = b;
        m_pending = 1'b1;
      end else begin
        a = AW'(m_addr);
        exp_q.push_back({a, m_hi, b});
        m_max_addr = m_addr;
        m_pending  = 1'b0;
        if (m_addr == N_WORD - 1) m_done = 1'b1;
        else m_addr++;
      end
    end
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    model_byte(b, stop_ok);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    t_last_stop = $time;
    drive_bit(stop_ok);
    repeat (1 + $urandom_range(0, 2)) drive_bit(1'b1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check("writes_drained", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    model_clear();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the expected queue on each write strobe.
  always @(negedge clk) begin
    logic [AW+15:0] e;
    if (rst_n) begin
      if (full_chk) begin
        check("done_after_last_addr", load_done, 1);
        full_chk = 1'b0;
      end
      if (frame_err) frame_seen++;
      if (load_done && !done_prev) t_done_rise = $time;
      if (wr_en) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write", wr_addr, wr_data);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", wr_addr, e[AW+15:16]);
          check("wr_data", wr_data, e[15:0]);
          check("max_addr_with_write", max_addr, e[AW+15:16]);
        end
        check("done_low_at_write", load_done, 0);
        if (wr_addr == AW'(N_WORD - 1)) full_chk = 1'b1;
      end
    end
    done_prev = load_done;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    longint diff;
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_max_addr", max_addr, 0);
    check("rst_load_done", load_done, 0);
    check("rst_frame_err", frame_err, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single pair
    send_byte(8'hA5, 1'b1);
    send_byte(8'h5A, 1'b1);
    wait_drain();
    check("pair_max_addr", max_addr, 0);
    check("pair_done_low", load_done, 0);

    // Second word, an unpaired byte, then idle until the timeout
    send_byte(8'h3C, 1'b1);
    send_byte(8'h2B, 1'b1);
    send_byte(8'h10, 1'b1);
    wait_drain();
    t_done_rise = 0;
    for (int i = 0; i < 600 && !load_done; i++) @(posedge clk);
    @(negedge clk);
    #1;
    check("timeout_done", load_done, 1);
    // Stop sample lands 11 cycles into the stop bit; done follows ITB*CPB cycles later.
    diff = longint'(t_done_rise) - longint'(t_last_stop);
    check("timeout_latency", (diff >= 3294 && diff <= 3334), 1);
    check("timeout_max_addr", max_addr, m_max_addr);
    m_done = 1'b1;
    send_byte(8'h99, 1'b1);
    send_byte(8'h98, 1'b1);
    wait_drain();
    check("post_done_max_addr", max_addr, 1);

    do_reset();

    // Frame error on a standalone byte, then a good pair
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b1);
    send_byte(8'h56, 1'b1);
    wait_drain();
    check("frame_err_count_a", frame_seen, m_frame_exp);

    // Short low glitch while idle
    rx = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (2 * CPB) @(posedge clk);
    #1;
    check("glitch_no_frame_err", frame_seen, m_frame_exp);
    send_byte(8'($urandom), 1'b1);
    send_byte(8'($urandom), 1'b1);
    wait_drain();

    // Random bytes with occasional frame errors until the address space fills
    while (!m_done) send_byte(8'($urandom), $urandom_range(0, 7) != 0);
    wait_drain();
    repeat (3) @(posedge clk);
    #1;
    check("full_done", load_done, 1);
    check("full_max_addr", max_addr, N_WORD - 1);
    send_byte(8'($urandom), 1'b1);
    send_byte(8'($urandom), 1'b1);
    send_byte(8'($urandom), 1'b0);
    wait_drain();
    check("frame_err_after_done", frame_seen, m_frame_exp);
    check("full_max_addr_hold", max_addr, N_WORD - 1);

    do_reset();

    // Reset in the middle of a byte
    send_byte(8'hA1, 1'b1);
    send_byte(8'hB2, 1'b1);
    send_byte(8'hC3, 1'b1);
    send_byte(8'hD4, 1'b1);
    send_byte(8'hE5, 1'b1);
    wait_drain();
    check("pre_reset_max_addr", max_addr, 1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    #3;
    rst_n = 1'b0;
    #2;
    check("async_rst_wr_en", wr_en, 0);
    check("async_rst_wr_addr", wr_addr, 0);
    check("async_rst_wr_data", wr_data, 0);
    check("async_rst_max_addr", max_addr, 0);
    check("async_rst_done", load_done, 0);
    rx = 1'b1;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_byte(8'hBE, 1'b1);
    send_byte(8'hEF, 1'b1);
    wait_drain();
    check("after_rst_max_addr", max_addr, 0);
    check("after_rst_done", load_done, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
